// File: rtl/npu_pkg.sv
// Shared NPU definitions: bus/address widths, the latched layer configuration
// and the instruction generator state encoding.
package npu_pkg;

  localparam int XLEN            = 32;
  localparam int ADDR_WIDTH      = 32;
  localparam int FRAM_ADDR_WIDTH = 20;
  localparam int KRAM_ADDR_WIDTH = 16;

  typedef enum logic {
    IG_IDLE  = 1'b0,
    IG_ISSUE = 1'b1
  } instgen_state_t;

  // Per-layer instruction fields held constant while a layer is being issued
  typedef struct packed {
    logic [XLEN-1:0]            chin;
    logic [XLEN-1:0]            chout;
    logic [XLEN-1:0]            width;
    logic [XLEN-1:0]            height;
    logic [7:0]                 kernel_sizeh;
    logic [7:0]                 kernel_sizew;
    logic                       has_bias;
    logic                       has_relu;
    logic [7:0]                 stride;
    logic [XLEN-1:0]            out_width;
    logic [XLEN-1:0]            out_height;
    logic [KRAM_ADDR_WIDTH-1:0] kernel_base;
  } layer_cfg_t;

endpackage

// File: rtl/instgen_addr_walker.sv
// Raster walker over the output plane: ox/oy counters plus the feature-window
// and write-back address accumulators, all advanced with adders only.
module instgen_addr_walker
  import npu_pkg::*;
#(
  parameter int W = XLEN
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         advance,
  input  logic [W-1:0] feat_base,
  input  logic [W-1:0] wb_base,
  input  logic [W-1:0] col_step,
  input  logic [W-1:0] row_step,
  input  logic [W-1:0] out_width,
  output logic [W-1:0] ox,
  output logic [W-1:0] oy,
  output logic [W-1:0] feat,
  output logic [W-1:0] wb
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] row_feat;

  always_ff @(posedge clk) begin
    if (rst) begin
      ox       <= '0;
      oy       <= '0;
      feat     <= '0;
      wb       <= '0;
      row_feat <= '0;
    end else if (start) begin
      ox       <= '0;
      oy       <= '0;
      feat     <= feat_base;
      wb       <= wb_base;
      row_feat <= feat_base;
    end else if (advance) begin
      wb <= wb + ONE;
      // ox < out_width always holds here, so ox+1 cannot overflow
      if (ox + ONE < out_width) begin
        ox   <= ox + ONE;
        feat <= feat + col_step;
      end else begin
        ox       <= '0;
        oy       <= oy + ONE;
        row_feat <= row_feat + row_step;
        feat     <= row_feat + row_step;
      end
    end
  end

endmodule

// File: rtl/instgen.sv
// Convolution instruction generator: latches one layer config and issues one
// instruction per output pixel in raster order, tlast on the final pixel.
module instgen
  import npu_pkg::*;
#(
  parameter int ADDR_WIDTH      = npu_pkg::ADDR_WIDTH,
  parameter int XLEN            = npu_pkg::XLEN,
  parameter int FRAM_ADDR_WIDTH = npu_pkg::FRAM_ADDR_WIDTH,
  parameter int KRAM_ADDR_WIDTH = npu_pkg::KRAM_ADDR_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDR_WIDTH-1:0]      feature_baseaddr,
  input  logic [ADDR_WIDTH-1:0]      kernel_baseaddr,
  input  logic [XLEN-1:0]            feature_width,
  input  logic [XLEN-1:0]            feature_height,
  input  logic [XLEN-1:0]            feature_chin,
  input  logic [XLEN-1:0]            feature_chout,
  input  logic [7:0]                 kernel_sizeh,
  input  logic [7:0]                 kernel_sizew,
  input  logic                       has_bias,
  input  logic                       has_relu,
  input  logic [7:0]                 stride,
  input  logic [ADDR_WIDTH-1:0]      output_baseaddr,
  input  logic [XLEN-1:0]            output_width,
  input  logic [XLEN-1:0]            output_height,
  input  logic                       csrcmd_valid,
  output logic                       instgen_ready,
  output logic [FRAM_ADDR_WIDTH-1:0] stride_feature_baseaddr,
  output logic [KRAM_ADDR_WIDTH-1:0] stride_kernel_baseaddr,
  output logic [XLEN-1:0]            stride_feature_chin,
  output logic [XLEN-1:0]            stride_feature_chout,
  output logic [XLEN-1:0]            stride_feature_width,
  output logic [XLEN-1:0]            stride_feature_height,
  output logic [7:0]                 stride_kernel_sizeh,
  output logic [7:0]                 stride_kernel_sizew,
  output logic                       stride_has_bias,
  output logic                       stride_has_relu,
  output logic [FRAM_ADDR_WIDTH-1:0] stride_wb_baseaddr,
  output logic [XLEN-1:0]            stride_wb_ch_offset,
  output logic                       inst_valid,
  output logic                       tlast,
  input  logic                       decoder_ready
);

  localparam logic [XLEN-1:0] ONE = XLEN'(1);

  instgen_state_t  state_q, state_d;
  layer_cfg_t      cfg_q;
  logic [XLEN-1:0] row_step_q;
  logic [XLEN-1:0] ch_offset_q;
  logic            empty_q;

  logic            start;
  logic            xfer;
  logic            last;
  logic            advance;
  logic [XLEN-1:0] ox, oy, feat, wb;

  assign start = (state_q == IG_IDLE) && csrcmd_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IG_IDLE;
      cfg_q       <= '0;
      row_step_q  <= '0;
      ch_offset_q <= '0;
      empty_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start) begin
        cfg_q.chin         <= feature_chin;
        cfg_q.chout        <= feature_chout;
        cfg_q.width        <= feature_width;
        cfg_q.height       <= feature_height;
        cfg_q.kernel_sizeh <= kernel_sizeh;
        cfg_q.kernel_sizew <= kernel_sizew;
        cfg_q.has_bias     <= has_bias;
        cfg_q.has_relu     <= has_relu;
        cfg_q.stride       <= stride;
        cfg_q.out_width    <= output_width;
        cfg_q.out_height   <= output_height;
        cfg_q.kernel_base  <= kernel_baseaddr[KRAM_ADDR_WIDTH-1:0];
        // One multiply per layer; the per-pixel walk only adds
        row_step_q         <= feature_width * XLEN'(stride);
        ch_offset_q        <= output_width * output_height;
        empty_q            <= (output_width == '0) || (output_height == '0);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IG_IDLE:  if (csrcmd_valid) state_d = IG_ISSUE;
      IG_ISSUE: if (empty_q || (xfer && last)) state_d = IG_IDLE;
      default:  state_d = IG_IDLE;
    endcase
  end

  // An empty layer spends one cycle in ISSUE with nothing valid
  assign inst_valid    = (state_q == IG_ISSUE) && !empty_q;
  assign instgen_ready = (state_q == IG_IDLE);
  assign last          = (ox == cfg_q.out_width - ONE) && (oy == cfg_q.out_height - ONE);
  assign tlast         = inst_valid && last;
  assign xfer          = inst_valid && decoder_ready;
  assign advance       = xfer && !last;

  instgen_addr_walker #(.W(XLEN)) u_walker (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .advance   (advance),
    .feat_base (XLEN'(feature_baseaddr)),
    .wb_base   (XLEN'(output_baseaddr)),
    .col_step  (XLEN'(cfg_q.stride)),
    .row_step  (row_step_q),
    .out_width (cfg_q.out_width),
    .ox        (ox),
    .oy        (oy),
    .feat      (feat),
    .wb        (wb)
  );

  assign stride_feature_baseaddr = feat[FRAM_ADDR_WIDTH-1:0];
  assign stride_wb_baseaddr      = wb[FRAM_ADDR_WIDTH-1:0];
  assign stride_kernel_baseaddr  = cfg_q.kernel_base;
  assign stride_feature_chin     = cfg_q.chin;
  assign stride_feature_chout    = cfg_q.chout;
  assign stride_feature_width    = cfg_q.width;
  assign stride_feature_height   = cfg_q.height;
  assign stride_kernel_sizeh     = cfg_q.kernel_sizeh;
  assign stride_kernel_sizew     = cfg_q.kernel_sizew;
  assign stride_has_bias         = cfg_q.has_bias;
  assign stride_has_relu         = cfg_q.has_relu;
  assign stride_wb_ch_offset     = ch_offset_q;

  logic unused_bits;
  assign unused_bits = ^{kernel_baseaddr[ADDR_WIDTH-1:KRAM_ADDR_WIDTH],
                         feat[XLEN-1:FRAM_ADDR_WIDTH], wb[XLEN-1:FRAM_ADDR_WIDTH]};

endmodule

// File: tb/tb_instgen.sv
// Self-checking bench for instgen: directed scenarios plus random layers,
// compared against a closed-form address model of the raster walk.
module tb_instgen;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] feature_baseaddr, kernel_baseaddr, output_baseaddr;
  logic [31:0] feature_width, feature_height, feature_chin, feature_chout;
  logic [7:0]  kernel_sizeh, kernel_sizew, stride;
  logic        has_bias, has_relu;
  logic [31:0] output_width, output_height;
  logic        csrcmd_valid, decoder_ready;
  logic        instgen_ready, inst_valid, tlast;
  logic [19:0] stride_feature_baseaddr, stride_wb_baseaddr;
  logic [15:0] stride_kernel_baseaddr;
  logic [31:0] stride_feature_chin, stride_feature_chout, stride_feature_width, stride_feature_height;
  logic [7:0]  stride_kernel_sizeh, stride_kernel_sizew;
  logic        stride_has_bias, stride_has_relu;
  logic [31:0] stride_wb_ch_offset;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model parameters (what the layer was started with)
  longint unsigned m_fb, m_ob, m_fw, m_stride, m_ow, m_oh, m_chin, m_kb;

  logic [19:0] q_feat[$];
  logic [19:0] q_wb[$];
  bit          q_last[$];
  int          q_cyc[$];

  instgen dut (
    .clk(clk), .rst(rst),
    .feature_baseaddr(feature_baseaddr), .kernel_baseaddr(kernel_baseaddr),
    .feature_width(feature_width), .feature_height(feature_height),
    .feature_chin(feature_chin), .feature_chout(feature_chout),
    .kernel_sizeh(kernel_sizeh), .kernel_sizew(kernel_sizew),
    .has_bias(has_bias), .has_relu(has_relu), .stride(stride),
    .output_baseaddr(output_baseaddr), .output_width(output_width), .output_height(output_height),
    .csrcmd_valid(csrcmd_valid), .instgen_ready(instgen_ready),
    .stride_feature_baseaddr(stride_feature_baseaddr), .stride_kernel_baseaddr(stride_kernel_baseaddr),
    .stride_feature_chin(stride_feature_chin), .stride_feature_chout(stride_feature_chout),
    .stride_feature_width(stride_feature_width), .stride_feature_height(stride_feature_height),
    .stride_kernel_sizeh(stride_kernel_sizeh), .stride_kernel_sizew(stride_kernel_sizew),
    .stride_has_bias(stride_has_bias), .stride_has_relu(stride_has_relu),
    .stride_wb_baseaddr(stride_wb_baseaddr), .stride_wb_ch_offset(stride_wb_ch_offset),
    .inst_valid(inst_valid), .tlast(tlast), .decoder_ready(decoder_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got no end, required end of test");
    $fatal(1, "watchdog");
  end

  function automatic logic [19:0] exp_feat(input int k);
    longint unsigned ox = longint'(k) % m_ow;
    longint unsigned oy = longint'(k) / m_ow;
    bit [63:0] v = m_fb + oy * m_stride * m_fw + ox * m_stride;
    return v[19:0];
  endfunction

  function automatic logic [19:0] exp_wb(input int k);
    bit [63:0] v = m_ob + longint'(k);
    return v[19:0];
  endfunction

  task automatic drive_cfg(input longint unsigned fb, input longint unsigned ob, input longint unsigned fw,
                           input longint unsigned st, input longint unsigned ow, input longint unsigned oh,
                           input longint unsigned chin, input longint unsigned kb);
    feature_baseaddr = 32'(fb);  output_baseaddr = 32'(ob);
    feature_width    = 32'(fw);  feature_height  = 32'(fw / 2 + 1);
    stride           = 8'(st);   output_width    = 32'(ow);  output_height = 32'(oh);
    feature_chin     = 32'(chin); feature_chout  = 32'(chin * 2 + 1);
    kernel_baseaddr  = 32'(kb);  kernel_sizeh    = 8'd3;     kernel_sizew  = 8'd3;
    has_bias         = chin[0];  has_relu        = ~chin[0];
    m_fb = fb & 64'hFFFF_FFFF; m_ob = ob & 64'hFFFF_FFFF; m_fw = fw; m_stride = st;
    m_ow = ow; m_oh = oh; m_chin = chin; m_kb = kb;
  endtask

  task automatic start_layer();
    @(negedge clk); csrcmd_valid = 1'b1;
    @(negedge clk); csrcmd_valid = 1'b0;
  endtask

  // Drives decoder_ready with random gaps and records every transfer until tlast
  task automatic collect(input int gap_max, input int budget, output bit timed_out);
    int gap = 0;
    int cyc = 0;
    bit done = 0;
    q_feat.delete(); q_wb.delete(); q_last.delete(); q_cyc.delete();
    while (!done && cyc < budget) begin
      if (cyc > 0) @(negedge clk);
      cyc++;
      decoder_ready = (gap == 0);
      if (inst_valid && decoder_ready) begin
        q_feat.push_back(stride_feature_baseaddr);
        q_wb.push_back(stride_wb_baseaddr);
        q_last.push_back(tlast);
        q_cyc.push_back(cyc);
        if (tlast) done = 1;
        gap = (gap_max == 0) ? 0 : int'($urandom_range(1, gap_max));
      end else if (gap > 0) gap--;
    end
    @(posedge clk); #1 decoder_ready = 1'b0;
    timed_out = !done;
  endtask

  task automatic test_reset();
    rst = 1'b1; csrcmd_valid = 1'b0; decoder_ready = 1'b0;
    drive_cfg(32'h1234, 32'h5678, 9, 2, 3, 3, 7, 32'hABCD);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (instgen_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b, required 1", instgen_ready); end
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, required 0", inst_valid); end
    n_checks++; if (tlast !== 1'b0) begin n_fail++; $display("FAIL reset_tlast: got %b, required 0", tlast); end
    n_checks++;
    if ({stride_feature_baseaddr, stride_wb_baseaddr, stride_kernel_baseaddr, stride_feature_chin,
         stride_feature_chout, stride_feature_width, stride_feature_height, stride_kernel_sizeh,
         stride_kernel_sizew, stride_has_bias, stride_has_relu, stride_wb_ch_offset} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got feat=%0h wb=%0h choff=%0h chin=%0h, required all zero",
                         stride_feature_baseaddr, stride_wb_baseaddr, stride_wb_ch_offset, stride_feature_chin);
    end
    rst = 1'b0;
  endtask

  task automatic test_main();
    bit to;
    int nl = 0;
    drive_cfg(0, 32'h10000, 20, 2, 18, 8, 3, 32'h0002_0040);
    feature_height = 32'd10; feature_chout = 32'd32;
    start_layer();
    n_checks++; if (inst_valid !== 1'b1 || instgen_ready !== 1'b0) begin
      n_fail++; $display("FAIL main_start: got valid=%b ready=%b, required valid=1 ready=0", inst_valid, instgen_ready); end
    n_checks++; if (stride_wb_ch_offset !== 32'd144) begin
      n_fail++; $display("FAIL main_ch_offset: got %0d, required 144", stride_wb_ch_offset); end
    n_checks++; if (stride_feature_chout !== 32'd32 || stride_feature_height !== 32'd10 || stride_kernel_baseaddr !== 16'h0040) begin
      n_fail++; $display("FAIL main_latched: got chout=%0d h=%0d kb=%0h, required 32 10 40",
                         stride_feature_chout, stride_feature_height, stride_kernel_baseaddr); end
    collect(3, 2000, to);
    n_checks++; if (to || q_feat.size() != 144) begin
      n_fail++; $display("FAIL main_count: got %0d transfers (timeout=%0b), required 144", q_feat.size(), to); end
    if (q_feat.size() == 144) begin
      n_checks++; if (q_feat[0] !== 20'd0 || q_wb[0] !== 20'h10000) begin
        n_fail++; $display("FAIL main_first: got feat=%0d wb=%0h, required 0 10000", q_feat[0], q_wb[0]); end
      n_checks++; if (q_feat[18] !== 20'd40 || q_wb[18] !== 20'h10012) begin
        n_fail++; $display("FAIL main_row2: got feat=%0d wb=%0h, required 40 10012", q_feat[18], q_wb[18]); end
      n_checks++; if (q_feat[143] !== 20'd314 || q_last[143] !== 1'b1) begin
        n_fail++; $display("FAIL main_last: got feat=%0d tlast=%b, required 314 1", q_feat[143], q_last[143]); end
      for (int i = 0; i < 144; i++) begin
        if (q_last[i]) nl++;
        n_checks++; if (q_feat[i] !== exp_feat(i) || q_wb[i] !== exp_wb(i)) begin
          n_fail++; $display("FAIL main_addr[%0d]: got feat=%0h wb=%0h, required %0h %0h",
                             i, q_feat[i], q_wb[i], exp_feat(i), exp_wb(i)); end
      end
      n_checks++; if (nl != 1) begin n_fail++; $display("FAIL main_tlast_count: got %0d, required 1", nl); end
    end
    @(negedge clk);
    n_checks++; if (instgen_ready !== 1'b1 || inst_valid !== 1'b0 || tlast !== 1'b0) begin
      n_fail++; $display("FAIL main_idle: got ready=%b valid=%b tlast=%b, required 1 0 0", instgen_ready, inst_valid, tlast); end
  endtask

  task automatic test_backpressure();
    bit to;
    logic [19:0] f0, w0;
    drive_cfg(32'h300, 32'h800, 11, 3, 5, 3, 4, 32'h10);
    start_layer();
    f0 = stride_feature_baseaddr; w0 = stride_wb_baseaddr;
    n_checks++; if (f0 !== exp_feat(0) || w0 !== exp_wb(0)) begin
      n_fail++; $display("FAIL bp_first: got feat=%0h wb=%0h, required %0h %0h", f0, w0, exp_feat(0), exp_wb(0)); end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_checks++; if (inst_valid !== 1'b1 || stride_feature_baseaddr !== f0 || stride_wb_baseaddr !== w0 || tlast !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got valid=%b feat=%0h wb=%0h, required 1 %0h %0h",
                           c, inst_valid, stride_feature_baseaddr, stride_wb_baseaddr, f0, w0); end
    end
    collect(2, 500, to);
    n_checks++; if (to || q_feat.size() != 15) begin
      n_fail++; $display("FAIL bp_count: got %0d (timeout=%0b), required 15", q_feat.size(), to); end
    for (int i = 0; i < q_feat.size(); i++) begin
      n_checks++; if (q_feat[i] !== exp_feat(i) || q_wb[i] !== exp_wb(i)) begin
        n_fail++; $display("FAIL bp_addr[%0d]: got %0h %0h, required %0h %0h", i, q_feat[i], q_wb[i], exp_feat(i), exp_wb(i)); end
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    drive_cfg(32'h40, 32'h200, 8, 1, 4, 2, 2, 0);
    start_layer();
    collect(0, 100, to);
    n_checks++; if (to || q_feat.size() != 8) begin
      n_fail++; $display("FAIL b2b_count: got %0d (timeout=%0b), required 8", q_feat.size(), to); end
    else begin
      n_checks++; if (q_cyc[7] - q_cyc[0] != 7 || q_last[7] !== 1'b1 || q_last[6] !== 1'b0) begin
        n_fail++; $display("FAIL b2b_timing: got span=%0d tlast7=%b tlast6=%b, required 7 1 0",
                           q_cyc[7] - q_cyc[0], q_last[7], q_last[6]); end
      for (int i = 0; i < 8; i++) begin
        n_checks++; if (q_feat[i] !== exp_feat(i) || q_wb[i] !== exp_wb(i)) begin
          n_fail++; $display("FAIL b2b_addr[%0d]: got %0h %0h, required %0h %0h", i, q_feat[i], q_wb[i], exp_feat(i), exp_wb(i)); end
      end
    end
  endtask

  task automatic test_busy_edge();
    bit to;
    drive_cfg(32'h100, 32'h900, 7, 2, 3, 2, 5, 32'h22);
    start_layer();
    // start again with a different layer while busy; neither must take effect
    csrcmd_valid = 1'b1; feature_baseaddr = 32'h5555; output_width = 32'd9; stride = 8'd7; output_baseaddr = 32'h0;
    @(negedge clk); csrcmd_valid = 1'b0;
    collect(1, 200, to);
    n_checks++; if (to || q_feat.size() != 6) begin
      n_fail++; $display("FAIL busy_count: got %0d (timeout=%0b), required 6", q_feat.size(), to); end
    for (int i = 0; i < q_feat.size(); i++) begin
      n_checks++; if (q_feat[i] !== exp_feat(i) || q_wb[i] !== exp_wb(i)) begin
        n_fail++; $display("FAIL busy_addr[%0d]: got %0h %0h, required %0h %0h", i, q_feat[i], q_wb[i], exp_feat(i), exp_wb(i)); end
    end
    @(negedge clk);
    drive_cfg(32'h100, 32'h900, 7, 1, 0, 5, 1, 0);
    decoder_ready = 1'b1;
    start_layer();
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL empty_valid1: got %b, required 0", inst_valid); end
    @(negedge clk);
    n_checks++; if (inst_valid !== 1'b0 || instgen_ready !== 1'b1) begin
      n_fail++; $display("FAIL empty_idle: got valid=%b ready=%b, required 0 1", inst_valid, instgen_ready); end
    @(negedge clk);
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL empty_valid2: got %b, required 0", inst_valid); end
    decoder_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit to;
    drive_cfg(32'h123, 32'h400, 10, 1, 6, 4, 3, 32'h99);
    start_layer();
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      decoder_ready = 1'b1;
    end
    @(negedge clk);
    n_checks++; if (stride_feature_baseaddr !== exp_feat(5)) begin
      n_fail++; $display("FAIL rstmid_pos: got %0h, required %0h", stride_feature_baseaddr, exp_feat(5)); end
    rst = 1'b1; decoder_ready = 1'b0;
    @(negedge clk);
    n_checks++; if (inst_valid !== 1'b0 || instgen_ready !== 1'b1 || stride_feature_baseaddr !== 20'd0) begin
      n_fail++; $display("FAIL rstmid_abort: got valid=%b ready=%b feat=%0h, required 0 1 0",
                         inst_valid, instgen_ready, stride_feature_baseaddr); end
    rst = 1'b0;
    drive_cfg(32'h777, 32'h400, 10, 1, 6, 4, 3, 32'h99);
    start_layer();
    n_checks++; if (stride_feature_baseaddr !== 20'h777 || stride_wb_baseaddr !== 20'h400) begin
      n_fail++; $display("FAIL rstmid_restart: got feat=%0h wb=%0h, required 777 400", stride_feature_baseaddr, stride_wb_baseaddr); end
    collect(2, 500, to);
    n_checks++; if (to || q_feat.size() != 24) begin
      n_fail++; $display("FAIL rstmid_count: got %0d (timeout=%0b), required 24", q_feat.size(), to); end
  endtask

  task automatic test_random();
    bit to;
    int nl;
    for (int l = 0; l < 6; l++) begin
      drive_cfg($urandom, $urandom, $urandom_range(1, 40), $urandom_range(1, 4),
                $urandom_range(1, 6), $urandom_range(1, 5), $urandom_range(1, 64), $urandom);
      start_layer();
      n_checks++; if (stride_wb_ch_offset !== 32'(m_ow * m_oh) || stride_kernel_baseaddr !== 16'(m_kb)
                      || stride_feature_chin !== 32'(m_chin)) begin
        n_fail++; $display("FAIL rnd_cfg[%0d]: got choff=%0d kb=%0h chin=%0d, required %0d %0h %0d",
                           l, stride_wb_ch_offset, stride_kernel_baseaddr, stride_feature_chin,
                           m_ow * m_oh, 16'(m_kb), m_chin); end
      collect(2, 1000, to);
      n_checks++; if (to || q_feat.size() != int'(m_ow * m_oh)) begin
        n_fail++; $display("FAIL rnd_count[%0d]: got %0d (timeout=%0b), required %0d", l, q_feat.size(), to, m_ow * m_oh); end
      nl = 0;
      for (int i = 0; i < q_feat.size(); i++) begin
        if (q_last[i]) nl++;
        n_checks++; if (q_feat[i] !== exp_feat(i) || q_wb[i] !== exp_wb(i)) begin
          n_fail++; $display("FAIL rnd_addr[%0d][%0d]: got %0h %0h, required %0h %0h",
                             l, i, q_feat[i], q_wb[i], exp_feat(i), exp_wb(i)); end
      end
      n_checks++; if (nl != 1) begin n_fail++; $display("FAIL rnd_tlast[%0d]: got %0d, required 1", l, nl); end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_main();
    test_backpressure();
    test_back_to_back();
    test_busy_edge();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
